// File: rtl/seg_pkg.sv
// Shared constants, duty type and arithmetic helpers for the segway motor drive.
// Used by seg_mtr_drv (optional SEG_MTR_SHADOW_EN build) and pwm11.
package seg_pkg;

  typedef logic [10:0] duty_t;

  localparam logic [11:0]        STEER_MIN = 12'h200;
  localparam logic [11:0]        STEER_MAX = 12'hE00;
  localparam logic [11:0]        STEER_CTR = 12'h7FF;
  localparam duty_t              DUTY_MID  = 11'h400;
  localparam logic signed [12:0] SPD_MAX   = 13'sd1023;
  localparam logic signed [12:0] SPD_MIN   = -13'sd1024;

  // Soft-start scaling: signed effort times unsigned 8-bit factor, divided by 256.
  function automatic logic signed [11:0] scale_pid(input logic signed [11:0] pid,
                                                  input logic [7:0]         ss);
    logic signed [20:0] prod;
    prod = $signed({{9{pid[11]}}, pid}) * $signed({13'd0, ss});
    return prod[19:8];
  endfunction

  function automatic logic signed [12:0] calc_steer(input logic [11:0] pot);
    logic [11:0]        clip;
    logic signed [12:0] x;
    logic signed [14:0] x3;
    logic signed [14:0] sh;
    if (pot < STEER_MIN) begin
      clip = STEER_MIN;
    end else if (pot > STEER_MAX) begin
      clip = STEER_MAX;
    end else begin
      clip = pot;
    end
    x  = $signed({1'b0, clip}) - $signed({1'b0, STEER_CTR});
    x3 = $signed({{2{x[12]}}, x}) + $signed({x[12], x, 1'b0});
    sh = x3 >>> 4;
    return sh[12:0];
  endfunction

  // Saturate to 11-bit signed speed and offset so 0x400 is standstill.
  function automatic duty_t spd_to_duty(input logic signed [12:0] spd);
    logic signed [12:0] sat;
    if (spd > SPD_MAX) begin
      sat = SPD_MAX;
    end else if (spd < SPD_MIN) begin
      sat = SPD_MIN;
    end else begin
      sat = spd;
    end
    return sat[10:0] + DUTY_MID;
  endfunction

endpackage

// File: rtl/seg_mtr_drv_pwm11.sv
// One H-bridge: 11-bit compare against the shared counter with dead-time interlock.
// Same behaviour in both SEG_MTR_SHADOW_EN builds.
module pwm11
  import seg_pkg::*;
#(
  parameter int NONOVERLAP = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  duty_t             duty,
  input  logic [10:0]       cnt,
  input  logic              pwr_up,
  output logic              PWM1,
  output logic              PWM2
);

  localparam logic [11:0] NOV = 12'(NONOVERLAP);

  logic        req1_s;
  logic        req2_s;
  logic        grant1_s;
  logic        grant2_s;
  logic [11:0] lo1_r;
  logic [11:0] lo2_r;

  // Leg requests from the counter compare; a leg may only rise once the other
  // leg has been low for NONOVERLAP cycles, which also covers mid-period duty changes.
  always_comb begin
    req1_s   = ({1'b0, cnt} >= NOV) && (cnt < duty);
    req2_s   = {1'b0, cnt} >= ({1'b0, duty} + NOV);
    grant1_s = pwr_up && req1_s && (lo2_r >= NOV);
    grant2_s = pwr_up && req2_s && (lo1_r >= NOV);
  end

  // Registered leg outputs and saturating low-time counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PWM1  <= 1'b0;
      PWM2  <= 1'b0;
      lo1_r <= 12'd0;
      lo2_r <= 12'd0;
    end else begin
      PWM1  <= grant1_s;
      PWM2  <= grant2_s;
      lo1_r <= grant1_s ? 12'd0 : ((lo1_r >= NOV) ? lo1_r : lo1_r + 12'd1);
      lo2_r <= grant2_s ? 12'd0 : ((lo2_r >= NOV) ? lo2_r : lo2_r + 12'd1);
    end
  end

endmodule

// File: rtl/seg_mtr_drv.sv
// Segway motor drive: soft-start scaling, steering mix and dead-time PWM for both bridges.
// Define SEG_MTR_SHADOW_EN to update the active duty only at period boundaries.
module seg_mtr_drv
  import seg_pkg::*;
#(
  parameter int NONOVERLAP = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic        pwr_up,
  input  logic        en_steer,
  input  logic [11:0] PID_cntrl,
  input  logic [7:0]  ss_tmr,
  input  logic [11:0] steer_pot,
  output logic        lft_PWM1,
  output logic        lft_PWM2,
  output logic        rght_PWM1,
  output logic        rght_PWM2
);

  logic signed [11:0] pid_ss_r;
  logic signed [12:0] steer_r;
  logic               ld_r;
  logic [10:0]        cnt_r;
  logic signed [12:0] lft_spd_s;
  logic signed [12:0] rght_spd_s;
  duty_t              lft_duty_s;
  duty_t              rght_duty_s;
  duty_t              lft_duty_r;
  duty_t              rght_duty_r;

  // Stage 1: capture scaled effort and steering offset on the vld strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_ss_r <= 12'sd0;
      steer_r  <= 13'sd0;
      ld_r     <= 1'b0;
    end else begin
      ld_r <= vld;
      if (vld) begin
        pid_ss_r <= scale_pid($signed(PID_cntrl), ss_tmr);
        steer_r  <= en_steer ? calc_steer(steer_pot) : 13'sd0;
      end
    end
  end

  // Per-motor mix and conversion to duty.
  always_comb begin
    lft_spd_s   = $signed({pid_ss_r[11], pid_ss_r}) + steer_r;
    rght_spd_s  = $signed({pid_ss_r[11], pid_ss_r}) - steer_r;
    lft_duty_s  = spd_to_duty(lft_spd_s);
    rght_duty_s = spd_to_duty(rght_spd_s);
  end

`ifdef SEG_MTR_SHADOW_EN
  duty_t lft_shadow_r;
  duty_t rght_shadow_r;

  // Shadow loads after stage 1; the active duty only changes on the 2047->0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_shadow_r  <= DUTY_MID;
      rght_shadow_r <= DUTY_MID;
      lft_duty_r    <= DUTY_MID;
      rght_duty_r   <= DUTY_MID;
    end else begin
      if (ld_r) begin
        lft_shadow_r  <= lft_duty_s;
        rght_shadow_r <= rght_duty_s;
      end
      if (cnt_r == 11'h7FF) begin
        lft_duty_r  <= lft_shadow_r;
        rght_duty_r <= rght_shadow_r;
      end
    end
  end
`else
  // Active duty follows stage 1 immediately, even mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_duty_r  <= DUTY_MID;
      rght_duty_r <= DUTY_MID;
    end else if (ld_r) begin
      lft_duty_r  <= lft_duty_s;
      rght_duty_r <= rght_duty_s;
    end
  end
`endif

  // Free-running period counter shared by both bridges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 11'd0;
    end else begin
      cnt_r <= cnt_r + 11'd1;
    end
  end

  pwm11 #(.NONOVERLAP(NONOVERLAP)) u_lft (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty   (lft_duty_r),
    .cnt    (cnt_r),
    .pwr_up (pwr_up),
    .PWM1   (lft_PWM1),
    .PWM2   (lft_PWM2)
  );

  pwm11 #(.NONOVERLAP(NONOVERLAP)) u_rght (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty   (rght_duty_r),
    .cnt    (cnt_r),
    .pwr_up (pwr_up),
    .PWM1   (rght_PWM1),
    .PWM2   (rght_PWM2)
  );

endmodule

// File: tb/tb_seg_mtr_drv.sv
// Self-checking bench for seg_mtr_drv: directed cases plus random transactions
// checked per period against an arithmetic reference of the duty/PWM rules.
module tb_seg_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic        pwr_up;
  logic        en_steer;
  logic [11:0] PID_cntrl;
  logic [7:0]  ss_tmr;
  logic [11:0] steer_pot;
  logic        lft_PWM1;
  logic        lft_PWM2;
  logic        rght_PWM1;
  logic        rght_PWM2;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  seg_mtr_drv #(.NONOVERLAP(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .pwr_up    (pwr_up),
    .en_steer  (en_steer),
    .PID_cntrl (PID_cntrl),
    .ss_tmr    (ss_tmr),
    .steer_pot (steer_pot),
    .lft_PWM1  (lft_PWM1),
    .lft_PWM2  (lft_PWM2),
    .rght_PWM1 (rght_PWM1),
    .rght_PWM2 (rght_PWM2)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the counter value compared at edge k is (k-1) mod 2048.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic int model_duty(int pid12, int ss, int pot, bit en, bit right);
    int pid, pss, c, st, spd;
    pid = (pid12 >= 2048) ? pid12 - 4096 : pid12;
    pss = (pid * ss) >>> 8;
    c   = (pot < 512) ? 512 : ((pot > 3584) ? 3584 : pot);
    st  = en ? ((3 * (c - 2047)) >>> 4) : 0;
    spd = right ? pss - st : pss + st;
    if (spd > 1023)  spd = 1023;
    if (spd < -1024) spd = -1024;
    return spd + 1024;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic align_to(input int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(edges >= 1 && ((edges - 1) % 2048) == target) && n < 5000);
    checks++;
    assert (n < 5000) else begin
      errors++;
      $error("FAIL align_timeout: waited %0d cycles for cnt %0d", n, target);
    end
  endtask

  task automatic check_period(input string tag, input int dl, input int dr);
    int ml = 0, mr = 0, ov = 0, hl1 = 0, hl2 = 0, c;
    bit e1l, e2l, e1r, e2r;
    align_to(2047);
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      c   = (edges - 1) % 2048;
      e1l = (c >= 32) && (c < dl);
      e2l = (c >= dl + 32);
      e1r = (c >= 32) && (c < dr);
      e2r = (c >= dr + 32);
      if (lft_PWM1 !== e1l || lft_PWM2 !== e2l) ml++;
      if (rght_PWM1 !== e1r || rght_PWM2 !== e2r) mr++;
      if ((lft_PWM1 && lft_PWM2) || (rght_PWM1 && rght_PWM2)) ov++;
      if (lft_PWM1 === 1'b1) hl1++;
      if (lft_PWM2 === 1'b1) hl2++;
    end
    chk({tag, "_lft_bad_cycles"}, ml, 0);
    chk({tag, "_rght_bad_cycles"}, mr, 0);
    chk({tag, "_overlap"}, ov, 0);
    chk({tag, "_lft_pwm1_hi"}, hl1, (dl > 32) ? dl - 32 : 0);
    chk({tag, "_lft_pwm2_hi"}, hl2, (dl < 2016) ? 2016 - dl : 0);
  endtask

  task automatic send(input int pid, input int ss, input int pot, input bit en);
    PID_cntrl = 12'(pid);
    ss_tmr    = 8'(ss);
    steer_pot = 12'(pot);
    en_steer  = en;
    vld       = 1'b1;
    @(negedge clk);
    vld       = 1'b0;
  endtask

  initial begin
    int pid, ss, pot, pid_a;
    bit en;
    rst_n = 1'b0; vld = 1'b0; pwr_up = 1'b1; en_steer = 1'b0;
    PID_cntrl = 12'd0; ss_tmr = 8'd0; steer_pot = 12'd0;
    #1;
    chk("reset_outputs", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_period("idle", 1024, 1024);

    align_to(1950); send(12'h100, 8'hFF, 12'h7FF, 1'b0);
    check_period("soft_start", 1279, 1279);

    align_to(1950); send(0, 8'hFF, 12'hFFF, 1'b1);
    check_period("steer_right", 1312, 736);

    align_to(1950); send(12'h7FF, 8'hFF, 12'h7FF, 1'b0);
    check_period("sat_pos", 2047, 2047);

    align_to(1950); send(12'h800, 8'hFF, 12'h7FF, 1'b0);
    check_period("sat_neg", 0, 0);

    pid = int'($urandom_range(0, 4095)); pot = int'($urandom_range(0, 4095));
    align_to(1950); send(pid, 0, pot, 1'b0);
    check_period("zero_ss", 1024, 1024);

    // Two back-to-back strobes: the second one must win.
    pid_a = int'($urandom_range(0, 4095)); pid = int'($urandom_range(0, 4095));
    align_to(1950);
    PID_cntrl = 12'(pid_a); ss_tmr = 8'hC0; steer_pot = 12'h300; en_steer = 1'b1; vld = 1'b1;
    @(negedge clk);
    PID_cntrl = 12'(pid); steer_pot = 12'hA00;
    @(negedge clk);
    vld = 1'b0;
    check_period("b2b_vld", model_duty(pid, 192, 2560, 1'b1, 1'b0),
                 model_duty(pid, 192, 2560, 1'b1, 1'b1));

    for (int k = 0; k < 6; k++) begin
      pid = int'($urandom_range(0, 4095));
      ss  = int'($urandom_range(0, 255));
      pot = int'($urandom_range(0, 4095));
      en  = 1'($urandom_range(0, 1));
      align_to(1950); send(pid, ss, pot, en);
      check_period("random", model_duty(pid, ss, pot, en, 1'b0),
                   model_duty(pid, ss, pot, en, 1'b1));
    end

    // Mid-period duty change 1024 -> 1279 issued around cnt 500.
    align_to(1950); send(0, 8'hFF, 12'h7FF, 1'b0);
    check_period("pre_shadow", 1024, 1024);
    align_to(498); send(12'h100, 8'hFF, 12'h7FF, 1'b0);
    align_to(1100);
`ifdef SEG_MTR_SHADOW_EN
    chk("same_period_pwm1", int'(lft_PWM1), 0);
    chk("same_period_pwm2", int'(lft_PWM2), 1);
`else
    chk("same_period_pwm1", int'(lft_PWM1), 1);
    chk("same_period_pwm2", int'(lft_PWM2), 0);
`endif
    align_to(1100);
    chk("next_period_pwm1", int'(lft_PWM1), 1);

    align_to(600);
    chk("pre_pwrdn", int'(lft_PWM1), 1);
    pwr_up = 1'b0;
    @(posedge clk); #1;
    chk("pwrdn_outputs", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}), 0);
    @(negedge clk);
    pwr_up = 1'b1;
    check_period("pwr_restore", 1279, 1279);

    align_to(700);
    chk("pre_reset", int'(lft_PWM1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_period("post_reset", 1024, 1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_mtr_drv.md
# seg_mtr_drv

- Converts the balance controller's signed `PID_cntrl` into complementary, dead-time-protected H-bridge PWM for the left and right motors.
- Applies the soft-start ramp `ss_tmr` and an optional steering offset from `steer_pot`.
- Sits between the PID block and the motor power stage.
- Samples on the same `vld` strobe that qualifies the controller output.

## Interface
- `NONOVERLAP`, default 32: dead-time in clk cycles between one PWM leg falling and the other rising.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `vld` input, 1 bit: single-cycle strobe; new `PID_cntrl`/`steer_pot` are valid.
- `pwr_up` input, 1 bit: drive enable; low forces all PWM outputs low.
- `en_steer` input, 1 bit: rider present and steering allowed.
- `PID_cntrl` input, 12 bits, signed: controller effort.
- `ss_tmr` input, 8 bits, unsigned: soft-start scale, where 0xFF means approximately unity.
- `steer_pot` input, 12 bits, unsigned: steering potentiometer reading.
- `lft_PWM1`, `lft_PWM2` output, 1 bit each: left bridge, forward and reverse legs.
- `rght_PWM1`, `rght_PWM2` output, 1 bit each: right bridge, forward and reverse legs.

## Operation
- **Scale on `vld`, registered in stage 1:**
  - prod = signed(`PID_cntrl`) × {1'b0,`ss_tmr`}, 21 bits.
  - PID_ss = prod[19:8], 12-bit signed, arithmetic shift.
- **Steering:**
  - Clip `steer_pot` to [0x200, 0xE00].
  - x = clip − 0x7FF, 13-bit signed.
  - steer = (x×3)>>>4, floor. Range is −288 to +288.
  - steer is forced to 0 when `en_steer`=0.
- **Per-motor speed:**
  - lft = PID_ss + steer; rght = PID_ss − steer, both 13-bit signed.
  - Saturate each to 11-bit signed [−1024, 1023].
- **Duty:** duty = spd + 0x400, 11-bit unsigned. 0x400 means 50%, i.e. stopped.
- **Counter:** free-running 11-bit cnt, 0..2047, wraps 2047→0. Period is 2048 clk.
- **Per bridge, registered:**
  - PWM1 = (cnt ≥ NONOVERLAP) && (cnt < duty).
  - PWM2 = (cnt ≥ duty+NONOVERLAP), compared at 12 bits. If duty+NONOVERLAP > 2047, PWM2 is never high.
  - PWM1 and PWM2 are never high in the same cycle for any duty.
- **`pwr_up`=0:** all four outputs are 0 on the next edge. Counter and duty registers keep running.
- **`vld` absent:** duty holds its last value.
- **Reset:**
  - cnt=0, stage regs=0, duty=0x400, all outputs 0.
  - Reset mid-period aborts the period immediately.

## Timing
- Stage 1 register: the edge carrying `vld`.
- Duty register: one cycle after stage 1, or per Configuration.
- Outputs: registered one cycle after cnt compare.
- Latency from `vld` to new duty visible on PWM: 2 cycles, or up to 2050 cycles with shadowing.
- `vld` in consecutive cycles: the last one wins. There is no back-pressure.

## Configuration
- Macro `SEG_MTR_SHADOW_EN`.
  - **Defined:** stage-1 duty loads into a shadow register. The active duty copies the shadow only on the cnt 2047→0 edge, so each period uses one consistent duty.
  - **Undefined:** active duty updates the cycle after stage 1, mid-period allowed. The dead-time guarantee still holds.

## Structure
- Package `seg_pkg`: STEER_MIN=0x200, STEER_MAX=0xE00, STEER_CTR=0x7FF, DUTY_MID=0x400, SPD_MAX=1023, SPD_MIN=−1024, typedef `duty_t` (logic [10:0]).
- Sub-module `pwm11`: counter compare and dead-time logic for one bridge.
  - Instantiated twice, sharing one counter passed in as `cnt`.
  - Ports: duty, cnt, pwr_up, PWM1, PWM2.

## Test plan
- **Soft start, no steering:** `PID_cntrl`=0x100, `ss_tmr`=0xFF, `en_steer`=0, one `vld`.
  - Required: both duty=1279.
  - PWM1 high cnt 32..1278 (1247 clk/period); PWM2 high cnt 1311..2047 (737 clk).
  - Never overlapping.
- **Full-right steering:** `PID_cntrl`=0, `steer_pot`=0xFFF, `en_steer`=1.
  - Required: steer=+288, lft duty=1312, rght duty=736.
- **Saturation:** `PID_cntrl`=0x7FF, `ss_tmr`=0xFF.
  - Required: PID_ss=2039, saturates to 1023, duty=2047.
  - PWM1 high cnt 32..2046; PWM2 never high.
  - `PID_cntrl`=0x800 gives duty=0: PWM1 never high, PWM2 high 32..2047.
- **Zero soft-start:** `ss_tmr`=0 with any `PID_cntrl`.
  - Required: duty=1024 on both motors.
- **Power-down and reset:** `pwr_up` dropped mid-period gives all outputs 0 on the next clk.
  - `rst_n` asserted mid-period gives outputs 0 asynchronously.
  - After release, cnt restarts at 0 and duty=1024.
- **Shadow loading (`SEG_MTR_SHADOW_EN`):** `vld` at cnt=500 changes duty from 1024 to 1279.
  - Required: the PWM1 edge stays at cnt 1024 for the current period.
  - The edge moves to 1279 from the next period.
  - Without the macro, the edge moves within the same period.
